vga_pixel_out: RTL and testbench
================================

VGA_PIXEL_OUT -- requirements
Module: vga_pixel_out

Interface
REQ-001 Parameters (name, default, meaning): HACTIVE 640 visible pixels/line; HFP 16 h front porch; HSW 96 hsync width; HFULLSCAN 800 pixels/line; VACTIVE 480 visible lines; VFP 10 v front porch; VSW 2 vsync width; VFULLSCAN 525 lines/frame; BLOCK 20 pixels per board block edge.
REQ-002 clk  input  1  pixel clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 row  input  10  horizontal pixel count from vga_controller, 0..HFULLSCAN-1.
REQ-005 col  input  10  line count from vga_controller, 0..VFULLSCAN-1.
REQ-006 re  input  1  board-memory read enable from vga_controller; read data valid next cycle.
REQ-007 updateoutput  input  1  colour-register update strobe from vga_controller.
REQ-008 rdata  input  3  tile code from board memory, 1-cycle read latency after re.
REQ-009 hsync, vsync  output  1 each  active-low sync pulses.
REQ-010 red, green, blue  output  4 each  pixel colour.

Function
REQ-011 Fixed 2-cycle latency: row/col sampled at cycle N drive sync and colour at N+2.
REQ-012 Stage 1 registers row, col, and tile_q; tile_q loads rdata only in the cycle after re=1, else holds.
REQ-013 Stage 1 keeps pixel-in-block counters bx (0..BLOCK-1) and by (0..BLOCK-1): bx clears when row==0, increments while row<HACTIVE, wraps BLOCK-1->0; by clears when col==0, increments on row==HFULLSCAN-1 while col<VACTIVE, wraps BLOCK-1->0.
REQ-014 Frame counter fc (5 bits) increments once per frame, in the cycle where row==0 and col==0; wraps 31->0.
REQ-015 hsync=0 iff delayed row in [HACTIVE+HFP, HACTIVE+HFP+HSW-1] (656..751), else 1.
REQ-016 vsync=0 iff delayed col in [VACTIVE+VFP, VACTIVE+VFP+VSW-1] (490..491), else 1.
REQ-017 Active = delayed row<HACTIVE and delayed col<VACTIVE; when not active red/green/blue=0 regardless of updateoutput.
REQ-018 When active and delayed updateoutput=1, colour register loads the tile colour; when active and delayed updateoutput=0, colour register holds.
REQ-019 Tile colours (R,G,B): 0 empty 0,0,0; 1 head 0,F,0; 2 body 0,8,0; 3 food F,0,0 if fc[4]=0 else 0,0,0; 4 wall 8,8,8; 5..7 reserved F,0,F.
REQ-020 Grid line: when active and (bx==0 or by==0) and tile code 0, colour is 2,2,2.
REQ-021 Sync outputs register every cycle, independent of updateoutput.
REQ-022 re and updateoutput in same cycle: both honoured; tile_q update precedes colour selection by one stage.
REQ-023 row/col jumping mid-line (vga_controller reset): pipeline continues from new values with no special handling; outputs correct 2 cycles after.

Reset
REQ-024 reset=1 at a clock edge: red/green/blue=0, hsync=1, vsync=1, tile_q=0, bx=by=0, fc=0, all pipeline registers 0, effective that edge.
REQ-025 Reset mid-frame: first valid output 2 cycles after reset deasserts; no partial sync pulse emitted while reset=1.

Verification
REQ-026 Reset held 3 cycles with arbitrary inputs -> rgb=0, hsync=vsync=1 during reset and next 2 cycles if row/col are blanking values.
REQ-027 Sweep row 0..799 at col=0 -> hsync low exactly cycles where delayed row 656..751 (96 cycles), high elsewhere.
REQ-028 Full frame sweep -> vsync low exactly for lines 490..491 (1600 cycles); rgb=0 whenever row>=640 or col>=480.
REQ-029 re=1 with rdata=1 next cycle, updateoutput=1, row=25,col=25 -> rgb 0,F,0 two cycles later; rdata=3 at frame 16 -> rgb 0,0,0; at frame 0 -> F,0,0.
REQ-030 tile 0 at row=20,col=5 -> rgb 2,2,2; at row=21,col=5 -> 0,0,0.
REQ-031 updateoutput=0 for 4 active cycles while tile changes 1->4 -> rgb holds 0,F,0 until updateoutput returns 1, then 8,8,8.

Source files
------------

// File: rtl/vga_pixel_out.sv
// Two-stage VGA pixel pipeline: stage 1 registers scan position, tile code and block/frame counters;
// stage 2 registers sync pulses and the tile colour. Outputs follow row/col by exactly 2 cycles.
module vga_pixel_out #(
  parameter int HACTIVE   = 640,
  parameter int HFP       = 16,
  parameter int HSW       = 96,
  parameter int HFULLSCAN = 800,
  parameter int VACTIVE   = 480,
  parameter int VFP       = 10,
  parameter int VSW       = 2,
  parameter int VFULLSCAN = 525,
  parameter int BLOCK     = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] row,
  input  logic [9:0] col,
  input  logic       re,
  input  logic       updateoutput,
  input  logic [2:0] rdata,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);
  localparam int BW = (BLOCK > 1) ? $clog2(BLOCK) : 1;
  localparam logic [9:0]    H_ACT    = 10'(HACTIVE);
  localparam logic [9:0]    H_LAST   = 10'(HFULLSCAN - 1);
  localparam logic [9:0]    V_ACT    = 10'(VACTIVE);
  localparam logic [9:0]    HS_FIRST = 10'(HACTIVE + HFP);
  localparam logic [9:0]    HS_LAST  = 10'(HACTIVE + HFP + HSW - 1);
  localparam logic [9:0]    VS_FIRST = 10'(VACTIVE + VFP);
  localparam logic [9:0]    VS_LAST  = 10'(VACTIVE + VFP + VSW - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(BLOCK - 1);

  logic [9:0]    row_q, row_d, col_q, col_d;
  logic          upd_q, upd_d, re_q, re_d;
  logic [2:0]    tile_q, tile_d;
  logic [BW-1:0] bx_q, bx_d, by_q, by_d;
  logic [4:0]    fc_q, fc_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic [11:0]   rgb_q, rgb_d;
  logic [11:0]   tile_rgb;
  logic          active, grid;

  always_comb begin
    row_d  = row;
    col_d  = col;
    upd_d  = updateoutput;
    re_d   = re;
    tile_d = re_q ? rdata : tile_q;

    bx_d = bx_q;
    if (row == '0) begin
      bx_d = '0;
    end else if (row < H_ACT) begin
      bx_d = (bx_q == B_LAST) ? '0 : bx_q + 1'b1;
    end

    // End-of-line advance wins over the line-0 clear so line 1 sees by=1.
    by_d = by_q;
    if (row == H_LAST && col < V_ACT) begin
      by_d = (by_q == B_LAST) ? '0 : by_q + 1'b1;
    end else if (col == '0) begin
      by_d = '0;
    end

    fc_d = (row == '0 && col == '0) ? fc_q + 5'd1 : fc_q;

    active = (row_q < H_ACT) && (col_q < V_ACT);
    grid   = (bx_q == '0) || (by_q == '0);

    case (tile_q)
      3'd0:    tile_rgb = grid ? 12'h222 : 12'h000;
      3'd1:    tile_rgb = 12'h0F0;
      3'd2:    tile_rgb = 12'h080;
      3'd3:    tile_rgb = fc_q[4] ? 12'h000 : 12'hF00;
      3'd4:    tile_rgb = 12'h888;
      default: tile_rgb = 12'hF0F;
    endcase

    hsync_d = !((row_q >= HS_FIRST) && (row_q <= HS_LAST));
    vsync_d = !((col_q >= VS_FIRST) && (col_q <= VS_LAST));

    rgb_d = rgb_q;
    if (!active) begin
      rgb_d = '0;
    end else if (upd_q) begin
      rgb_d = tile_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q   <= '0;
      col_q   <= '0;
      upd_q   <= 1'b0;
      re_q    <= 1'b0;
      tile_q  <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      fc_q    <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      upd_q   <= upd_d;
      re_q    <= re_d;
      tile_q  <= tile_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      fc_q    <= fc_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign red   = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue  = rgb_q[3:0];
endmodule

// File: tb/tb_vga_pixel_out.sv
// Bench for vga_pixel_out: per-pixel record model with 2-cycle delay, directed and randomized scans.
module tb_vga_pixel_out;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] row = '0, col = '0;
  logic       re = 1'b0, updateoutput = 1'b0;
  logic [2:0] rdata = '0;
  logic       hsync, vsync;
  logic [3:0] red, green, blue;

  int checks = 0;
  int failures = 0;
  bit model_on = 1'b0;

  vga_pixel_out dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .re(re),
    .updateoutput(updateoutput), .rdata(rdata),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  // One record per sampled pixel: what the pipeline knows about it after stage 1.
  typedef struct {
    int r; int c; bit upd; int tile; int bx; int by; int fc;
  } rec_t;

  rec_t        st = '{0, 0, 1'b0, 0, 0, 0, 0};
  bit          m_re_d = 1'b0;
  logic [11:0] e_rgb = '0;
  logic        e_hs = 1'b1, e_vs = 1'b1;

  function automatic logic [11:0] tile_colour(int t, bit grid, bit fc4);
    case (t)
      0:       return grid ? 12'h222 : 12'h000;
      1:       return 12'h0F0;
      2:       return 12'h080;
      3:       return fc4 ? 12'h000 : 12'hF00;
      4:       return 12'h888;
      default: return 12'hF0F;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      e_rgb  = '0;
      e_hs   = 1'b1;
      e_vs   = 1'b1;
      st     = '{0, 0, 1'b0, 0, 0, 0, 0};
      m_re_d = 1'b0;
    end else begin
      rec_t nx;
      e_hs = !(st.r >= 656 && st.r <= 751);
      e_vs = !(st.c >= 490 && st.c <= 491);
      if (!(st.r < 640 && st.c < 480)) e_rgb = '0;
      else if (st.upd) e_rgb = tile_colour(st.tile, (st.bx == 0) || (st.by == 0), ((st.fc >> 4) & 1) == 1);
      nx.r   = int'(row);
      nx.c   = int'(col);
      nx.upd = updateoutput;
      nx.tile = m_re_d ? int'(rdata) : st.tile;
      nx.bx  = (row == 0) ? 0 : (row < 640) ? (st.bx + 1) % 20 : st.bx;
      nx.by  = (row == 799 && col < 480) ? (st.by + 1) % 20 : (col == 0) ? 0 : st.by;
      nx.fc  = (row == 0 && col == 0) ? (st.fc + 1) % 32 : st.fc;
      m_re_d = re;
      st = nx;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      checks++;
      if ({hsync, vsync, red, green, blue} !== {e_hs, e_vs, e_rgb}) begin
        failures++;
        $display("FAIL pixel t=%0t actual hs=%b vs=%b rgb=%h required hs=%b vs=%b rgb=%h",
                 $time, hsync, vsync, {red, green, blue}, e_hs, e_vs, e_rgb);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int r, input int c, input bit e, input bit u, input int d);
    @(negedge clk);
    row = 10'(r); col = 10'(c); re = e; updateoutput = u; rdata = 3'(d);
    @(posedge clk);
  endtask

  task automatic chk_rgb(input string name, input logic [11:0] exp);
    #1;
    chk(name, 32'({red, green, blue}), 32'(exp));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      row = 10'($urandom_range(0, 799)); col = 10'($urandom_range(0, 524));
      re = 1'($urandom); updateoutput = 1'($urandom); rdata = 3'($urandom);
      @(posedge clk);
      #1;
      chk("reset_rgb", 32'({red, green, blue}), 32'h0);
      chk("reset_sync", 32'({hsync, vsync}), 32'h3);
      model_on = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int r, c;
    do_reset(3);

    // Grid: by=1 after one end-of-line, then bx=0 at row 20 and bx=1 at row 21.
    step(799, 1, 0, 0, 0);
    for (int i = 0; i <= 21; i++) step(i, 5, 0, 1, 0);
    chk_rgb("grid_row20", 12'h222);
    step(22, 5, 0, 1, 0);
    chk_rgb("grid_row21", 12'h000);

    step(700, 25, 1, 0, 0); step(25, 25, 0, 1, 1); step(700, 25, 0, 0, 0);
    chk_rgb("head", 12'h0F0);
    step(700, 25, 1, 0, 0); step(25, 25, 0, 1, 3); step(700, 25, 0, 0, 0);
    chk_rgb("food_fc0", 12'hF00);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0);
    step(700, 25, 1, 0, 0); step(25, 25, 0, 1, 3); step(700, 25, 0, 0, 0);
    chk_rgb("food_fc16", 12'h000);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0);
    step(700, 25, 1, 0, 0); step(25, 25, 0, 1, 3); step(700, 25, 0, 0, 0);
    chk_rgb("food_fc_wrap", 12'hF00);

    // Colour hold while the tile changes underneath with updateoutput low.
    step(30, 30, 1, 0, 0); step(31, 30, 0, 1, 1); step(32, 30, 1, 0, 0);
    step(33, 30, 0, 0, 4); chk_rgb("hold_a", 12'h0F0);
    step(34, 30, 0, 0, 0); chk_rgb("hold_b", 12'h0F0);
    step(35, 30, 0, 0, 0); chk_rgb("hold_c", 12'h0F0);
    step(36, 30, 0, 1, 0); chk_rgb("hold_d", 12'h0F0);
    step(37, 30, 0, 0, 0); chk_rgb("wall", 12'h888);

    // Horizontal sweep: count hsync-low cycles.
    n = 0;
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    for (int j = 0; j < 802; j++) begin
      step((j < 800) ? j : 0, 0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)));
      #1;
      if (!hsync) n++;
    end
    chk("hsync_low_count", 32'(n), 32'd96);

    // Vertical band around the sync pulse: count vsync-low cycles.
    n = 0;
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    for (int cc = 485; cc <= 495; cc++) begin
      for (int rr = 0; rr < 800; rr++) begin
        step(rr, cc, 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)));
        #1;
        if (!vsync) n++;
      end
    end
    for (int j = 0; j < 2; j++) begin
      step(0, 0, 0, 0, 0);
      #1;
      if (!vsync) n++;
    end
    chk("vsync_low_count", 32'(n), 32'd1600);

    // Randomized scanning with occasional jumps and resets.
    r = int'($urandom_range(0, 799));
    c = int'($urandom_range(0, 524));
    for (int k = 0; k < 25000; k++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end
      if ($urandom_range(0, 199) == 0) begin
        r = int'($urandom_range(0, 799));
        c = int'($urandom_range(0, 524));
      end
      step(r, c, ($urandom_range(0, 2) == 0), 1'($urandom), int'($urandom_range(0, 7)));
      r++;
      if (r == 800) begin
        r = 0;
        c = (c == 524) ? 0 : c + 1;
      end
    end
    step(700, 500, 0, 0, 0);
    step(700, 500, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
